pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised successor to the team's plain n-bit register: a WIDTH-bit, STAGES-deep pipeline register chain.
- Each stage has a valid bit.
- Uses a valid/ready handshake on both ends, bubble collapsing, stall back-pressure and a synchronous flush.
- Sits between datapath blocks (ALU output to writeback, fetch to decode) wherever fixed latency with stall capability is needed.

Parameters:
- WIDTH, 32, data bits per stage.
- STAGES, 4, number of register stages; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous, active-high clear of all stage valid bits.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  last-stage data.
- occupancy  output  $clog2(STAGES+1)  count of valid stages.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset (rst=1 at posedge):
  - All stage valid bits = 0; all stage data = 0.
  - Therefore out_valid=0, out_data=0, occupancy=0 the next cycle.
  - rst has priority over flush and all handshakes.
  - rst mid-transfer discards every in-flight word.
- Stage i holds v[i] and d[i]; stage STAGES-1 is the output.
- Move enables, evaluated combinationally from the output back:
  - mv[STAGES-1] = out_ready | ~v[STAGES-1].
  - mv[i] = mv[i+1] | ~v[i+1] for i < STAGES-1 (bubble collapse: a stage advances into an empty successor even if downstream stalls).
- Stage 0 load when mv0 = ~v[0] | mv[1]; STAGES=1 uses out_ready | ~v[0].
- in_ready = mv0 & ~flush & ~rst.
  - Combinational from out_ready; no combinational path from in_valid to in_ready.
- When stage i's enable is set: v[i] <= v[i-1] and d[i] <= d[i-1]; stage 0 takes in_valid & in_ready and in_data.
- Data registers load only when the incoming valid is 1; bubbles leave d unchanged.
- Transfer out occurs when out_valid & out_ready.
- out_data and out_valid are registered outputs, with no combinational path from in_* to out_*.
- Latency: with out_ready held 1 and an empty chain, a word accepted at cycle t appears at out_valid in cycle t+STAGES.
- Throughput: 1 word/cycle sustained.
- Full (all v=1, out_ready=0): in_ready=0; all contents hold.
- Full with out_ready=1: the whole chain shifts; in_ready=1 the same cycle (simultaneous in and out).
- flush=1 at posedge:
  - All v <= 0; data unchanged; occupancy 0 the next cycle.
  - The input word is not accepted (in_ready=0).
  - An output transfer asserted in that same cycle still counts as consumed by downstream.
- occupancy is the registered popcount of v, updated each cycle, and never exceeds STAGES.
- in_valid must stay asserted with stable in_data until accepted. The bench checks this; the RTL does not.

Optional Feature:
- Macro: PIPE_REG_CHAIN_PARITY_EN.
- With the macro:
  - Each stage stores an extra even-parity bit computed from in_data at acceptance.
  - New output port out_perr (1 bit) = out_valid & (^out_data != stored parity), registered alongside out_data.
  - Reset and flush clear parity to 0.
- Without the macro: the port is absent, no parity storage, behaviour otherwise identical.

Decomposition:
- Package pipe_reg_pkg:
  - PIPE_WIDTH_DEFAULT=32 and PIPE_STAGES_DEFAULT=4.
  - PIPE_STAGES_MAX=16.
  - Function occ_width(stages) returning $clog2(stages+1).
- Sub-module pipe_stage:
  - One valid bit plus a WIDTH-bit data register with sync reset, clear and load enable.
  - Instanced STAGES times in a generate loop.
  - The chain top holds only the move-enable logic and the occupancy counter.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1, in_data=0xDEADBEEF → out_valid=0, out_data=0, occupancy=0, in_ready=0 during reset.
- Streaming: out_ready=1, send 0x1,0x2,...,0x8 back-to-back → out_data 0x1..0x8 in order, first at cycle t+4, no gaps, occupancy steady at 4.
- Stall/fill: out_ready=0, push 0xA0..0xA5 → first four accepted, in_ready=0 after the fourth, occupancy=4; raise out_ready → 0xA0..0xA3 then 0xA4,0xA5 with no loss or duplication.
- Bubble collapse: send 0x11, idle 2 cycles, send 0x22, hold out_ready=0 → both words pack into stages 3 and 2 and occupancy=2; then out_ready=1 → 0x11 then 0x22 on consecutive cycles.
- Flush: chain full with 0xB0..0xB3, assert flush with in_valid=1, in_data=0xCC → next cycle occupancy=0, out_valid=0, 0xCC never appears at the output.
- Parity (macro defined): force-corrupt bit 5 of stage 2 data via the bench → out_perr=1 exactly in the cycle that word is at the output; clean words give out_perr=0.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
// Shared defaults and helpers for the pipe_reg_chain pipeline register.
package pipe_reg_pkg;

    localparam int PIPE_WIDTH_DEFAULT  = 32;
    localparam int PIPE_STAGES_DEFAULT = 4;
    localparam int PIPE_STAGES_MAX     = 16;

    // Bits needed to count 0..stages valid entries.
    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: valid bit plus data register with sync reset, clear and load enable.
// With PIPE_REG_CHAIN_PARITY_EN defined, the stage also carries a parity bit.
module pipe_stage
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
`ifdef PIPE_REG_CHAIN_PARITY_EN
    input  logic             pin,
    output logic             p,
`endif
    output logic             v,
    output logic             v_nxt,
    output logic [WIDTH-1:0] d
);

    // Next valid is exported so the chain can register an exact occupancy.
    always_comb v_nxt = (rst | clr) ? 1'b0 : (en ? vin : v);

    // Bubbles and flushes leave the data register untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            v <= v_nxt;
            if (en && vin && !clr)
                d <= din;
        end
    end

`ifdef PIPE_REG_CHAIN_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || clr)
            p <= 1'b0;
        else if (en && vin)
            p <= pin;
    end
`endif

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: STAGES-deep valid/ready register pipeline with bubble collapse and flush.
// Define PIPE_REG_CHAIN_PARITY_EN to carry per-stage even parity and raise out_perr.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH  = PIPE_WIDTH_DEFAULT,
    parameter int STAGES = PIPE_STAGES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
`ifdef PIPE_REG_CHAIN_PARITY_EN
    output logic                         out_perr,
`endif
    output logic [occ_width(STAGES)-1:0] occupancy
);

    localparam int OW = occ_width(STAGES);

    if (STAGES < 1 || STAGES > PIPE_STAGES_MAX) begin : g_bad_stages
        $error("pipe_reg_chain: STAGES out of range");
    end

    logic [STAGES-1:0]            v, v_nxt, v_in, en;
    logic [STAGES-1:0][WIDTH-1:0] d, d_in;
    logic [OW-1:0]                occ_nxt;
`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic [STAGES-1:0]            p, p_in;
`endif

    // A stage loads when it is empty or its successor loads, so words
    // slide forward into holes even while the output is stalled.
    always_comb begin
        logic chain;
        chain = out_ready;
        en    = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain = ~v[i] | chain;
            en[i] = chain;
        end
    end

    assign in_ready = en[0] & ~flush & ~rst;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign v_in[i] = in_valid & in_ready;
            assign d_in[i] = in_data;
`ifdef PIPE_REG_CHAIN_PARITY_EN
            assign p_in[i] = ^in_data;
`endif
        end else begin : g_body
            assign v_in[i] = v[i-1];
            assign d_in[i] = d[i-1];
`ifdef PIPE_REG_CHAIN_PARITY_EN
            assign p_in[i] = p[i-1];
`endif
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clr   (flush),
            .en    (en[i]),
            .vin   (v_in[i]),
            .din   (d_in[i]),
`ifdef PIPE_REG_CHAIN_PARITY_EN
            .pin   (p_in[i]),
            .p     (p[i]),
`endif
            .v     (v[i]),
            .v_nxt (v_nxt[i]),
            .d     (d[i])
        );
    end

    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < STAGES; i++)
            occ_nxt = occ_nxt + OW'(v_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            occupancy <= '0;
        else
            occupancy <= occ_nxt;
    end

    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];
`ifdef PIPE_REG_CHAIN_PARITY_EN
    assign out_perr  = v[STAGES-1] & ((^d[STAGES-1]) ^ p[STAGES-1]);
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed scenarios plus a randomized
// run against a word-queue reference model.
module tb_pipe_reg_chain;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int OW = $clog2(S + 1);

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [OW-1:0] occupancy;
`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic          out_perr;
`endif

    int tests = 0;
    int fails = 0;
    logic [W-1:0] sb[$];

    pipe_reg_chain #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PIPE_REG_CHAIN_PARITY_EN
        .out_perr  (out_perr),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        @(negedge clk); #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        tests++; if (occupancy !== '0) begin fails++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready2: got %b expected 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0; #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_release_valid: got %b expected 0", out_valid); end
    endtask

    // Words 1..8 back to back; first output S cycles after acceptance, no gaps.
    task automatic test_streaming();
        int exp_occ;
        out_ready = 1'b1;
        for (int j = 0; j < 13; j++) begin
            in_valid = (j < 8);
            in_data  = W'(j + 1);
            #1;
            if (j < 8) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready c%0d: got %b expected 1", j, in_ready); end
            end
            tick();
            exp_occ = (j + 1 <= S) ? j + 1 : ((j + 1 <= 8) ? S : ((12 - (j + 1)) > 0 ? 12 - (j + 1) : 0));
            tests++; if (out_valid !== ((j + 1 >= S) && (j + 1 <= 11))) begin fails++; $display("FAIL stream_out_valid c%0d: got %b", j + 1, out_valid); end
            if ((j + 1 >= S) && (j + 1 <= 11)) begin
                tests++; if (out_data !== W'(j + 1 - 3)) begin fails++; $display("FAIL stream_out_data c%0d: got %h expected %h", j + 1, out_data, W'(j + 1 - 3)); end
            end
            tests++; if (occupancy !== OW'(exp_occ)) begin fails++; $display("FAIL stream_occ c%0d: got %0d expected %0d", j + 1, occupancy, exp_occ); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall_fill();
        int next_in = 0;
        int exp_idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_data = W'(32'hA0 + next_in); #1;
            tests++; if (in_ready !== (c < S)) begin fails++; $display("FAIL fill_in_ready c%0d: got %b expected %b", c, in_ready, c < S); end
            if (in_ready) next_in++;
            tick();
        end
        tests++; if (occupancy !== OW'(S)) begin fails++; $display("FAIL fill_occ: got %0d expected %0d", occupancy, S); end
        tests++; if (out_data !== 32'hA0) begin fails++; $display("FAIL fill_hold_data: got %h expected a0", out_data); end
        for (int c = 0; c < 12; c++) begin
            in_valid = (next_in < 6); in_data = W'(32'hA0 + next_in); out_ready = 1'b1; #1;
            if (c == 0) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_shift_ready: got %b expected 1", in_ready); end
            end
            if (out_valid) begin
                tests++; if (exp_idx >= 6 || out_data !== W'(32'hA0 + exp_idx)) begin fails++; $display("FAIL drain_data #%0d: got %h expected %h", exp_idx, out_data, W'(32'hA0 + exp_idx)); end
                exp_idx++;
            end
            if (in_valid && in_ready) next_in++;
            tick();
        end
        in_valid = 1'b0;
        tests++; if (exp_idx !== 6) begin fails++; $display("FAIL drain_count: got %0d expected 6", exp_idx); end
        tests++; if (occupancy !== '0) begin fails++; $display("FAIL drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_data = 32'h22; tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        tests++; if (occupancy !== OW'(2)) begin fails++; $display("FAIL bubble_occ: got %0d expected 2", occupancy); end
        out_ready = 1'b1; #1;
        tests++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin fails++; $display("FAIL bubble_first: got v=%b %h expected 11", out_valid, out_data); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 32'h22) begin fails++; $display("FAIL bubble_second: got v=%b %h expected 22", out_valid, out_data); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bubble_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b0;
            for (int c = 0; c < S; c++) begin
                in_valid = 1'b1; in_data = W'((k == 0 ? 32'hB0 : 32'hD0) + c); tick();
            end
            flush = 1'b1; in_valid = 1'b1; in_data = 32'hCC; out_ready = (k == 1); #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready k%0d: got %b expected 0", k, in_ready); end
            if (k == 1) begin
                tests++; if (out_valid !== 1'b1 || out_data !== 32'hD0) begin fails++; $display("FAIL flush_xfer: got v=%b %h expected d0", out_valid, out_data); end
            end
            tick();
            flush = 1'b0; in_valid = 1'b0;
            tests++; if (occupancy !== '0) begin fails++; $display("FAIL flush_occ k%0d: got %0d expected 0", k, occupancy); end
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid k%0d: got %b expected 0", k, out_valid); end
            out_ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                tick();
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_leak k%0d: got v=%b data %h", k, out_valid, out_data); end
            end
        end
    endtask

    task automatic test_random();
        logic         pend = 1'b0;
        logic         iv   = 1'b0;
        logic [W-1:0] dat  = '0;
        logic [W-1:0] exp_d;
        sb.delete();
        for (int c = 0; c < 2000; c++) begin
            if (!pend) begin
                iv  = ($urandom_range(0, 9) < 7);
                dat = $urandom;
            end
            in_valid  = iv;
            in_data   = dat;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            #1;
            tests++; if (in_ready !== (!flush && (sb.size() < S || out_ready))) begin fails++; $display("FAIL rand_in_ready c%0d: got %b, %0d queued", c, in_ready, sb.size()); end
            if (out_valid && sb.size() == 0) begin
                tests++; fails++; $display("FAIL rand_phantom c%0d: got valid %h with nothing queued", c, out_data);
            end else if (out_valid && out_ready) begin
                exp_d = sb.pop_front();
                tests++; if (out_data !== exp_d) begin fails++; $display("FAIL rand_data c%0d: got %h expected %h", c, out_data, exp_d); end
            end
`ifdef PIPE_REG_CHAIN_PARITY_EN
            tests++; if (out_perr !== 1'b0) begin fails++; $display("FAIL rand_perr c%0d: got %b expected 0", c, out_perr); end
`endif
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
            pend = in_valid && !in_ready;
            tick();
            tests++; if (occupancy !== OW'(sb.size())) begin fails++; $display("FAIL rand_occ c%0d: got %0d expected %0d", c, occupancy, sb.size()); end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < S + 2; c++) begin
            #1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    tests++; fails++; $display("FAIL rand_drain_extra: got %h with nothing queued", out_data);
                end else begin
                    exp_d = sb.pop_front();
                    tests++; if (out_data !== exp_d) begin fails++; $display("FAIL rand_drain_data: got %h expected %h", out_data, exp_d); end
                end
            end
            tick();
        end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL rand_drain_left: got %0d words stuck expected 0", sb.size()); end
    endtask

`ifdef PIPE_REG_CHAIN_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] w[4];
        logic [W-1:0] exp_d;
        int           idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < S; c++) begin
            w[c] = $urandom; in_valid = 1'b1; in_data = w[c]; tick();
        end
        in_valid = 1'b0;
        force u_dut.g_stage[2].u_stage.d = w[1] ^ 32'h20;
        #1;
        release u_dut.g_stage[2].u_stage.d;
        out_ready = 1'b1;
        for (int c = 0; c < S + 2; c++) begin
            #1;
            if (out_valid) begin
                exp_d = (idx == 1) ? (w[1] ^ 32'h20) : w[idx];
                tests++; if (out_data !== exp_d) begin fails++; $display("FAIL par_data #%0d: got %h expected %h", idx, out_data, exp_d); end
                tests++; if (out_perr !== (idx == 1)) begin fails++; $display("FAIL par_perr #%0d: got %b expected %b", idx, out_perr, idx == 1); end
                idx++;
            end
            tick();
        end
        tests++; if (idx !== 4) begin fails++; $display("FAIL par_count: got %0d expected 4", idx); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_bubble();
        test_flush();
`ifdef PIPE_REG_CHAIN_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
